// File: rtl/sar_avg.sv
// Block averager behind a SAR controller: sums 2^LOG2N conversions and publishes
// the rounded mean through a single-entry output buffer with an overrun flag.
module sar_avg #(
  parameter int DW    = 8,
  parameter int LOG2N = 2
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Enable,
  input  logic             Ready,
  input  logic [DW-1:0]    DataOut,
  output logic [DW-1:0]    AvgData,
  output logic             AvgValid,
  input  logic             AvgAccept,
  output logic             Overrun,
  input  logic             OvrClr,
  output logic [LOG2N-1:0] SampleCnt
);
  localparam int AW = DW + LOG2N;
  localparam logic [AW-1:0] HALF = AW'(1) << (LOG2N - 1);

  typedef enum logic {ACCUM, CLOSE} phase_t;

  phase_t        phase;
  logic          rdy_q;
  logic          smp;
  logic          close;
  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  // Only a Ready rising edge is a new conversion; ignored while disabled.
  assign smp = Ready & ~rdy_q & Enable;

  always_comb begin
    phase = ACCUM;
    if (SampleCnt == '1) phase = CLOSE;
  end

  assign close = smp && (phase == CLOSE);
  // Full block sum plus half an LSB never exceeds AW bits, so no carry is lost.
  assign sum   = acc + AW'(DataOut) + HALF;

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      rdy_q     <= 1'b0;
      acc       <= '0;
      SampleCnt <= '0;
      AvgData   <= '0;
      AvgValid  <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      rdy_q <= Ready;

      if (!Enable) begin
        acc       <= '0;
        SampleCnt <= '0;
      end else if (close) begin
        acc       <= '0;
        SampleCnt <= '0;
      end else if (smp) begin
        acc       <= acc + AW'(DataOut);
        SampleCnt <= SampleCnt + 1'b1;
      end

      if (close) begin
        AvgData  <= sum[AW-1:LOG2N];
        AvgValid <= 1'b1;
      end else if (AvgAccept) begin
        AvgValid <= 1'b0;
      end

      // A close that lands on an unconsumed result overwrites it; set beats clear.
      if (close && AvgValid && !AvgAccept) Overrun <= 1'b1;
      else if (OvrClr)                     Overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sar_avg.sv
// Randomized + directed bench for sar_avg: block-mean reference model feeding an
// expected-result queue, drained by a handshake monitor.
module tb_sar_avg;
  localparam int DW    = 8;
  localparam int LOG2N = 2;
  localparam int N     = 1 << LOG2N;

  logic             Clock = 1'b0;
  logic             ResetN = 1'b0;
  logic             Enable = 1'b0;
  logic             Ready = 1'b0;
  logic [DW-1:0]    DataOut = '0;
  logic [DW-1:0]    AvgData;
  logic             AvgValid;
  logic             AvgAccept = 1'b0;
  logic             Overrun;
  logic             OvrClr = 1'b0;
  logic [LOG2N-1:0] SampleCnt;

  sar_avg #(.DW(DW), .LOG2N(LOG2N)) dut (
    .Clock(Clock), .ResetN(ResetN), .Enable(Enable), .Ready(Ready),
    .DataOut(DataOut), .AvgData(AvgData), .AvgValid(AvgValid),
    .AvgAccept(AvgAccept), .Overrun(Overrun), .OvrClr(OvrClr),
    .SampleCnt(SampleCnt)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;
  bit rnd = 0;

  logic g_en = 1'b1, g_acc = 1'b0, g_clr = 1'b0, g_rn = 1'b0;

  // Reference state: samples of the open block, results awaiting consumption.
  int blk[$];
  int exp_q[$];
  bit m_ovr = 0;
  bit m_prv = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit edge_seen, ow;
    int s;
    if (!ResetN) begin
      blk.delete(); exp_q.delete(); m_ovr = 0; m_prv = 0;
      return;
    end
    edge_seen = Ready && !m_prv;
    m_prv = Ready;
    ow = 0;
    if (!Enable) blk.delete();
    else if (edge_seen) begin
      blk.push_back(int'(DataOut));
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        blk.delete();
        if (exp_q.size() != 0 && !AvgAccept) begin
          void'(exp_q.pop_back());
          ow = 1;
        end
        exp_q.push_back((s + N / 2) / N);
      end
    end
    if (ow) m_ovr = 1;
    else if (OvrClr) m_ovr = 0;
  endfunction

  // One clock: check the current state against the model, then drive and predict.
  task automatic cyc(input logic rdy, input int d);
    @(negedge Clock); #1;
    if (chk_on) begin
      chk("avg_valid", AvgValid, exp_q.size() != 0);
      chk("overrun", Overrun, m_ovr);
      chk("sample_cnt", SampleCnt, blk.size());
      if (exp_q.size() != 0) chk("avg_data_hold", AvgData, exp_q[0]);
    end
    if (rnd) begin
      g_acc = ($urandom_range(0, 9) < 7);
      g_clr = ($urandom_range(0, 9) == 0);
      g_en  = ($urandom_range(0, 49) != 0);
      g_rn  = ($urandom_range(0, 199) != 0);
    end
    ResetN = g_rn; Enable = g_en; Ready = rdy; DataOut = DW'(d);
    AvgAccept = g_acc; OvrClr = g_clr;
    model_step();
  endtask

  task automatic conv(input int d, input int hold, input int gap);
    for (int i = 0; i < hold; i++) cyc(1'b1, d);
    for (int i = 0; i < gap; i++) cyc(1'b0, 0);
  endtask

  // Monitor: a handshake seen before the edge consumes the oldest expected result.
  initial begin
    forever begin
      @(negedge Clock); #2;
      if (chk_on && ResetN && AvgValid && AvgAccept) begin
        if (exp_q.size() == 0) chk("accept_unexpected", 1, 0);
        else chk("accept_data", AvgData, exp_q.pop_front());
      end
    end
  end

  initial begin
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    chk_on = 1;
    g_rn = 1'b1;
    cyc(1'b0, 0);
    chk("rst_data", AvgData, 0);
    chk("rst_valid", AvgValid, 0);
    chk("rst_ovr", Overrun, 0);
    chk("rst_cnt", SampleCnt, 0);

    // Nominal mean with an explicit one-cycle latency look.
    conv(10, 1, 1); conv(11, 1, 1); conv(12, 1, 1);
    cyc(1'b1, 13);
    chk("s1_pre_valid", AvgValid, 0);
    cyc(1'b0, 0);
    chk("s1_lat_valid", AvgValid, 1);
    chk("s1_avg", AvgData, 12);
    g_acc = 1'b1; cyc(1'b0, 0); g_acc = 1'b0;

    // Rounding and full-scale.
    conv(1, 1, 1); conv(1, 1, 1); conv(1, 1, 1); conv(2, 1, 1);
    chk("s2_round", AvgData, 1);
    g_acc = 1'b1; cyc(1'b0, 0); g_acc = 1'b0;
    for (int i = 0; i < 4; i++) conv(255, 2, 1);
    chk("s2_max", AvgData, 255);
    chk("s2_max_ovr", Overrun, 0);
    g_acc = 1'b1; cyc(1'b0, 0); g_acc = 1'b0;

    // Held Ready counts once.
    conv(50, 5, 2); conv(60, 5, 2);
    chk("s3_cnt", SampleCnt, 2);
    conv(70, 5, 2); conv(80, 5, 2);
    chk("s3_avg", AvgData, 65);
    g_acc = 1'b1; cyc(1'b0, 0); g_acc = 1'b0;

    // Overrun across two unconsumed blocks, then clear.
    for (int i = 0; i < 4; i++) conv(20, 1, 1);
    for (int i = 0; i < 4; i++) conv(40, 1, 1);
    chk("s4_data", AvgData, 40);
    chk("s4_valid", AvgValid, 1);
    chk("s4_ovr", Overrun, 1);
    g_clr = 1'b1; cyc(1'b0, 0); g_clr = 1'b0;
    cyc(1'b0, 0);
    chk("s4_clr", Overrun, 0);
    g_acc = 1'b1; cyc(1'b0, 0); g_acc = 1'b0;

    // Accept coinciding with the close edge.
    for (int i = 0; i < 4; i++) conv(30, 1, 1);
    for (int i = 0; i < 3; i++) conv(90, 1, 1);
    g_acc = 1'b1; cyc(1'b1, 94); g_acc = 1'b0;
    cyc(1'b0, 0);
    chk("s5_data", AvgData, 91);
    chk("s5_valid", AvgValid, 1);
    chk("s5_ovr", Overrun, 0);

    // Enable drop keeps the pending result; reset mid-block clears everything.
    conv(5, 1, 1); conv(6, 1, 1);
    g_en = 1'b0; cyc(1'b0, 0); g_en = 1'b1;
    cyc(1'b0, 0);
    chk("s6_cnt", SampleCnt, 0);
    chk("s6_keep_valid", AvgValid, 1);
    chk("s6_keep_data", AvgData, 91);
    conv(7, 1, 1); conv(8, 1, 1);
    g_rn = 1'b0; cyc(1'b0, 0); g_rn = 1'b1;
    cyc(1'b1, 100);
    chk("s6_rst_data", AvgData, 0);
    chk("s6_rst_valid", AvgValid, 0);
    chk("s6_rst_cnt", SampleCnt, 0);
    chk("s6_rst_ovr", Overrun, 0);
    // Ready already high right after release is a fresh sample.
    cyc(1'b0, 0);
    chk("s6_first_edge", SampleCnt, 1);

    // Randomized traffic.
    rnd = 1;
    for (int k = 0; k < 400; k++)
      conv($urandom_range(0, 255), $urandom_range(1, 3), $urandom_range(1, 2));
    rnd = 0;
    g_rn = 1'b1; g_en = 1'b1; g_acc = 1'b1; g_clr = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
